// File: rtl/spi_master_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_pkg
// Shared definitions for the multi-chip-select SPI master:
//   - state_e       : frame sequencer states
//   - *_DEFAULT     : default NCS / DW / DIVW parameter values
//   - calcLw()      : width of the frame-length field for a given DW
//   - calcCsw()     : width of the chip-select index for a given NCS
// ---------------------------------------------------------------------------
package spi_master_pkg;

    localparam int NCS_DEFAULT  = 4;
    localparam int DW_DEFAULT   = 32;
    localparam int DIVW_DEFAULT = 8;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        LAG,
        GAP,
        RESP
    } state_e;

    // Length field holds (bits - 1), so clog2 of the maximum frame size.
    function automatic int calcLw(input int dw);
        return $clog2(dw);
    endfunction

    // A single device still needs a one-bit select index.
    function automatic int calcCsw(input int ncs);
        return (ncs > 1) ? $clog2(ncs) : 1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// ---------------------------------------------------------------------------
// spi_clkgen
// Half-period divider and SCLK generator for the SPI master.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   run_i          : divider counts while high, held at zero otherwise
//   load_i         : start of frame, clears counter and parks SCLK
//   load_pol_i     : SCLK idle level to park at on load_i
//   toggle_i       : SCLK is allowed to toggle at the end of a half-period
//   pol_i          : registered idle level, used to classify edges
//   div_i          : half-period length minus one, in clock cycles
//   sclk_o         : serial clock
//   tick_o         : last cycle of the current half-period
//   lead_o/trail_o : strobes for the edge SCLK is about to make
// ---------------------------------------------------------------------------
module spi_clkgen
    import spi_master_pkg::*;
#(
    parameter int DIVW = DIVW_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            run_i,
    input  logic            load_i,
    input  logic            load_pol_i,
    input  logic            toggle_i,
    input  logic            pol_i,
    input  logic [DIVW-1:0] div_i,
    output logic            sclk_o,
    output logic            tick_o,
    output logic            lead_o,
    output logic            trail_o
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;

    // The counter wraps to zero at the terminal count rather than
    // incrementing, so an all-ones divider never overflows.
    // An edge leaving the idle level is a leading edge, returning is trailing.
    always_comb begin
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        tick_o  = run_i && (cnt_q == div_i);
        lead_o  = tick_o && toggle_i && (sclk_q == pol_i);
        trail_o = tick_o && toggle_i && (sclk_q != pol_i);
        if (load_i) begin
            cnt_d  = '0;
            sclk_d = load_pol_i;
        end else if (!run_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
            if (toggle_i) begin
                sclk_d = ~sclk_q;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_mc.sv
// ---------------------------------------------------------------------------
// spi_master_mc
// SPI master with NCS chip selects / SDI lanes, variable frame length,
// all four SPI modes and a programmable SCLK divider.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   req_valid/req_ready      : frame request handshake (ready only in IDLE)
//   req_cs, req_len, req_data: target device, bits-1, right-justified word
//   cfg_cpol, cfg_cpha       : SPI mode, captured with the request
//   cfg_div                  : SCLK half-period = cfg_div+1 CLK cycles
//   rsp_valid/rsp_ready      : response handshake, held until accepted
//   rsp_data, rsp_err        : received word, out-of-range chip select flag
//   sclk, sdo, sdi, csb      : SPI bus (csb active low)
// Optional feature: define SPI_MASTER_MC_LOOPBACK_EN to add input lpbk,
// which, when captured high, samples sdo instead of the selected sdi lane.
// ---------------------------------------------------------------------------
module spi_master_mc
    import spi_master_pkg::*;
#(
    parameter  int NCS  = NCS_DEFAULT,
    parameter  int DW   = DW_DEFAULT,
    parameter  int DIVW = DIVW_DEFAULT,
    localparam int LW   = calcLw(DW),
    localparam int CSW  = calcCsw(NCS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CSW-1:0]  req_cs,
    input  logic [LW-1:0]   req_len,
    input  logic [DW-1:0]   req_data,
    input  logic            cfg_cpol,
    input  logic            cfg_cpha,
    input  logic [DIVW-1:0] cfg_div,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            rsp_err,
    output logic            sclk,
    output logic            sdo,
    input  logic [NCS-1:0]  sdi,
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    input  logic            lpbk,
`endif
    output logic [NCS-1:0]  csb
);

    // Edge counter must reach 2*(len+1)-1.
    localparam int EW = LW + 1;

    state_e          state_q, state_d;

    logic [CSW-1:0]  cs_q;
    logic [LW-1:0]   len_q;
    logic [DW-1:0]   data_q;
    logic            cpol_q;
    logic            cpha_q;
    logic [DIVW-1:0] div_q;
    logic            err_q;
    logic [LW-1:0]   bitIdx_q;
    logic [EW-1:0]   edgeCnt_q;
    logic [DW-1:0]   rx_q;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    logic            lpbk_q;
`endif

    logic accept;
    logic csActive;
    logic divRun;
    logic sclkToggle;
    logic tick;
    logic leadEdge;
    logic trailEdge;
    logic lastEdge;
    logic sampleEdge;
    logic shiftEdge;
    logic laneBit;
    logic sampleBit;

    assign accept     = req_valid && (state_q == IDLE);
    assign csActive   = (state_q == LEAD) || (state_q == SHIFT) || (state_q == LAG);
    assign divRun     = csActive || (state_q == GAP);
    assign sclkToggle = (state_q == LEAD) || (state_q == SHIFT);
    assign lastEdge   = (edgeCnt_q == {len_q, 1'b1});

    spi_clkgen #(
        .DIVW (DIVW)
    ) u_clkgen (
        .clk_i      (CLK),
        .rst_i      (RST),
        .run_i      (divRun),
        .load_i     (accept),
        .load_pol_i (cfg_cpol),
        .toggle_i   (sclkToggle),
        .pol_i      (cpol_q),
        .div_i      (div_q),
        .sclk_o     (sclk),
        .tick_o     (tick),
        .lead_o     (leadEdge),
        .trail_o    (trailEdge)
    );

    // The first leading edge closes LEAD, so SHIFT spans the remaining
    // 2*(len+1)-1 edges and ends on the final trailing edge.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && lastEdge) begin
                    state_d = LAG;
                end
            end
            LAG: begin
                if (tick) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CPHA=0 samples on leading edges and advances on trailing edges,
    // skipping the final one so the index never underflows.
    // CPHA=1 advances on every leading edge except the first, which
    // merely launches the MSB already on sdo, and samples on trailing.
    assign sampleEdge = cpha_q ? trailEdge : leadEdge;
    assign shiftEdge  = cpha_q ? (leadEdge && (edgeCnt_q != '0))
                               : (trailEdge && !lastEdge);

    assign laneBit = err_q ? 1'b0 : sdi[cs_q];
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    assign sampleBit = lpbk_q ? sdo : laneBit;
`else
    assign sampleBit = laneBit;
`endif

    // Request fields are frozen at accept; the shift register is cleared
    // then so unused upper bits of the response read as zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_q      <= '0;
            len_q     <= '0;
            data_q    <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            err_q     <= 1'b0;
            bitIdx_q  <= '0;
            edgeCnt_q <= '0;
            rx_q      <= '0;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
            lpbk_q    <= 1'b0;
`endif
        end else if (accept) begin
            cs_q      <= req_cs;
            len_q     <= req_len;
            data_q    <= req_data;
            cpol_q    <= cfg_cpol;
            cpha_q    <= cfg_cpha;
            div_q     <= cfg_div;
            err_q     <= (int'(req_cs) >= NCS);
            bitIdx_q  <= req_len;
            edgeCnt_q <= '0;
            rx_q      <= '0;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
            lpbk_q    <= lpbk;
`endif
        end else begin
            if (leadEdge || trailEdge) begin
                edgeCnt_q <= edgeCnt_q + 1'b1;
            end
            if (sampleEdge) begin
                rx_q <= {rx_q[DW-2:0], sampleBit};
            end
            if (shiftEdge) begin
                bitIdx_q <= bitIdx_q - 1'b1;
            end
        end
    end

    // Only the addressed device is selected, and sdo is forced low whenever
    // no device is selected, including out-of-range frames.
    always_comb begin
        csb = '1;
        for (int i = 0; i < NCS; i++) begin
            if (csActive && !err_q && (int'(cs_q) == i)) begin
                csb[i] = 1'b0;
            end
        end
    end

    assign sdo      = csActive && !err_q && data_q[bitIdx_q];
    assign rsp_data = rx_q;
    assign rsp_err  = err_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// ---------------------------------------------------------------------------
// tb_spi_master_mc
// Self-checking bench for spi_master_mc (NCS=5 so out-of-range selects
// are reachable). A bus monitor/slave process watches SCLK, counts pulses,
// records sdo on sampling edges and drives sdi; expected results come from
// the frame description with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_spi_master_mc;

    localparam int NCS  = 5;
    localparam int DW   = 32;
    localparam int DIVW = 8;
    localparam int LW   = 5;
    localparam int CSW  = 3;

    logic            CLK;
    logic            RST;
    logic            req_valid;
    logic            req_ready;
    logic [CSW-1:0]  req_cs;
    logic [LW-1:0]   req_len;
    logic [DW-1:0]   req_data;
    logic            cfg_cpol;
    logic            cfg_cpha;
    logic [DIVW-1:0] cfg_div;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            sclk;
    logic            sdo;
    logic [NCS-1:0]  sdi;
    logic            lpbk;
    logic [NCS-1:0]  csb;

    int checks = 0;
    int errors = 0;

    // Frame description, written only by the stimulus process.
    int             fGen = 0;
    logic [CSW-1:0] fCs = '0;
    int             fLen = 0;
    logic [DW-1:0]  fSlave = '0;
    logic           fCpol = 1'b0;
    logic           fCpha = 1'b0;

    // Monitor results, written only by the monitor process.
    int             mGen;
    int             mPulses;
    int             mEdges;
    logic [DW-1:0]  mCap;
    int             mMinHp;
    int             mMaxHp;
    int             mHp;
    logic [NCS-1:0] mCsbLead;
    int             mViol;
    logic           mActive;
    logic           mPrev;
    int             mPtr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    spi_master_mc #(
        .NCS  (NCS),
        .DW   (DW),
        .DIVW (DIVW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cs    (req_cs),
        .req_len   (req_len),
        .req_data  (req_data),
        .cfg_cpol  (cfg_cpol),
        .cfg_cpha  (cfg_cpha),
        .cfg_div   (cfg_div),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sclk      (sclk),
        .sdo       (sdo),
        .sdi       (sdi),
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        .lpbk      (lpbk),
`endif
        .csb       (csb)
    );

    // Bus monitor and SPI slave, sampling on the falling CLK edge.
    initial begin
        logic lead;
        logic b;
        mGen = 0; mPulses = 0; mEdges = 0; mCap = '0; mMinHp = 0; mMaxHp = 0;
        mHp = 0; mCsbLead = '1; mViol = 0; mActive = 1'b0; mPrev = 1'b0;
        mPtr = -1; sdi = '0;
        forever begin
            @(negedge CLK);
            if ($countones(~csb) > 1) mViol++;
            if ((&csb) && sdo) mViol++;
            if (fGen != mGen) begin
                mGen = fGen; mActive = 1'b0; mPulses = 0; mEdges = 0; mCap = '0;
                mMinHp = 1 << 30; mMaxHp = 0; mHp = 0; mCsbLead = '1;
                mPtr = fCpha ? fLen + 1 : fLen;
            end else if (!mActive) begin
                if (!req_ready && !RST) begin
                    mActive = 1'b1; mPrev = sclk; mHp = 0;
                end
            end else begin
                mHp++;
                if (sclk !== mPrev) begin
                    lead = (mPrev == fCpol);
                    if (mEdges > 0) begin
                        if (mHp < mMinHp) mMinHp = mHp;
                        if (mHp > mMaxHp) mMaxHp = mHp;
                    end
                    mEdges++; mHp = 0;
                    if (lead) begin
                        mPulses++; mCsbLead = csb;
                    end
                    if (lead != fCpha) mCap = {mCap[DW-2:0], sdo};
                    if (lead == fCpha) mPtr--;
                    mPrev = sclk;
                end
            end
            b = (mPtr >= 0 && mPtr <= fLen) ? fSlave[mPtr] : 1'b0;
            for (int i = 0; i < NCS; i++) sdi[i] = (i == int'(fCs)) ? b : ~b;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, "_csb"}, 64'(csb), 64'(5'b11111));
        checkOutput({tag, "_sdo"}, 64'(sdo), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic startFrame(input logic [CSW-1:0] cs, input int len, input logic [DW-1:0] data,
                              input logic [DW-1:0] slave, input logic cpol, input logic cpha,
                              input logic [DIVW-1:0] div, input logic lp);
        @(posedge CLK); #1;
        fCs = cs; fLen = len; fSlave = slave; fCpol = cpol; fCpha = cpha;
        fGen++;
        req_cs = cs; req_len = len[LW-1:0]; req_data = data;
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_div = div; lpbk = lp;
        checkOutput("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        // Scramble the request side; the frame must use the captured values.
        req_data = $urandom; req_len = LW'($urandom); req_cs = CSW'($urandom);
        cfg_cpol = ~cpol; cfg_cpha = ~cpha; cfg_div = DIVW'($urandom); lpbk = ~lp;
    endtask

    task automatic applyStimulus(input logic [CSW-1:0] cs, input int len, input logic [DW-1:0] data,
                                 input logic [DW-1:0] slave, input logic cpol, input logic cpha,
                                 input logic [DIVW-1:0] div, input logic lp, input int hold,
                                 input logic second, input logic early);
        logic [63:0]    mask;
        logic [DW-1:0]  expRx;
        logic [DW-1:0]  expTx;
        logic [NCS-1:0] expCsb;
        logic           err;
        int             n;
        int             budget;
        err    = (int'(cs) >= NCS);
        mask   = (64'd1 << (len + 1)) - 64'd1;
        expTx  = err ? '0 : (data & mask[DW-1:0]);
        expRx  = err ? '0 : ((lp ? data : slave) & mask[DW-1:0]);
        for (int i = 0; i < NCS; i++) expCsb[i] = !(!err && (i == int'(cs)));
        budget = (2 * (len + 1) + 4) * (int'(div) + 1) + 10;

        startFrame(cs, len, data, slave, cpol, cpha, div, lp);
        checkOutput("csb_after_accept", 64'(csb), 64'(expCsb));
        checkOutput("ready_in_frame", 64'(req_ready), 64'd0);
        if (!cpha && !err) checkOutput("sdo_first_bit", 64'(sdo), 64'(data[len]));
        if (early) begin
            rsp_ready = 1'b1;
            repeat (2) @(posedge CLK);
            #1 rsp_ready = 1'b0;
        end

        n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        checkOutput("rsp_timeout", 64'(n < budget), 64'd1);
        checkOutput("rsp_data", 64'(rsp_data), 64'(expRx));
        checkOutput("rsp_err", 64'(rsp_err), 64'(err));
        checkOutput("pulses", 64'(mPulses), 64'(len + 1));
        checkOutput("sdo_stream", 64'(mCap), 64'(expTx));
        checkOutput("csb_in_frame", 64'(mCsbLead), 64'(expCsb));
        checkOutput("half_period_min", 64'(mMinHp), 64'(int'(div) + 1));
        checkOutput("half_period_max", 64'(mMaxHp), 64'(int'(div) + 1));
        checkOutput("sclk_idle", 64'(sclk), 64'(cpol));
        checkOutput("csb_released", 64'(csb), 64'(5'b11111));

        for (int k = 0; k < hold; k++) begin
            if (second) begin
                req_valid = 1'b1; req_data = ~data; req_cs = '0;
            end
            @(posedge CLK); #1;
            checkOutput("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("hold_rsp_data", 64'(rsp_data), 64'(expRx));
            checkOutput("hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        checkOutput("back_to_idle_valid", 64'(rsp_valid), 64'd0);
        checkOutput("back_to_idle_ready", 64'(req_ready), 64'd1);
        if (second) begin
            @(posedge CLK); #1;
            checkIdleBus("no_second_frame");
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] s;
        logic          sawResp;
        int            n;
        RST = 1'b1; req_valid = 1'b0; req_cs = '0; req_len = '0; req_data = '0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = '0; rsp_ready = 1'b0; lpbk = 1'b0;
        $display("[TB] start");

        repeat (3) @(posedge CLK);
        #1;
        checkIdleBus("reset");
        checkOutput("reset_sclk", 64'(sclk), 64'd0);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
        RST = 1'b0;

        // Mode 0, fastest clock, device 2, 0xA5 out / 0x3C in; a stray
        // rsp_ready during the frame must be ignored.
        applyStimulus(3'd2, 7, 32'hA5, 32'h3C, 1'b0, 1'b0, 8'd0, 1'b0, 2, 1'b0, 1'b1);

        // Mode 3, half-period of 4 cycles, full 32-bit word.
        applyStimulus(3'd1, 31, 32'hDEADBEEF, $urandom, 1'b1, 1'b1, 8'd3, 1'b0, 0, 1'b0, 1'b0);

        // Out-of-range device.
        applyStimulus(3'd5, 7, $urandom, 32'hFF, 1'b0, 1'b0, 8'd1, 1'b0, 0, 1'b0, 1'b0);

        // Response held back 20 cycles with a competing request pending.
        applyStimulus(3'd4, 7, $urandom, $urandom, 1'b0, 1'b1, 8'd0, 1'b0, 20, 1'b1, 1'b0);

        // Largest divider, short frame.
        applyStimulus(3'd0, 1, 32'h2, 32'h1, 1'b1, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);

        // Randomized frames across devices, lengths and modes.
        for (int t = 0; t < 14; t++) begin
            logic lp;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
            lp = 1'($urandom);
`else
            lp = 1'b0;
`endif
            d = $urandom; s = $urandom;
            applyStimulus(CSW'($urandom_range(0, 7)), int'($urandom_range(0, 31)), d, s,
                          1'($urandom), 1'($urandom), DIVW'($urandom_range(0, 4)), lp,
                          int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

`ifdef SPI_MASTER_MC_LOOPBACK_EN
        applyStimulus(3'd3, 15, 32'h1234, 32'h0, 1'b0, 1'b0, 8'd0, 1'b1, 0, 1'b0, 1'b0);
`endif

        // Reset during the fourth bit of a 16-bit frame.
        startFrame(3'd1, 15, $urandom, $urandom, 1'b1, 1'b0, 8'd1, 1'b0);
        n = 0;
        while (mPulses < 4 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        checkOutput("reach_bit3_timeout", 64'(n < 200), 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        checkIdleBus("mid_reset");
        checkOutput("mid_reset_sclk", 64'(sclk), 64'd0);
        checkOutput("mid_reset_rsp_data", 64'(rsp_data), 64'd0);
        RST = 1'b0;
        sawResp = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK); #1;
            if (rsp_valid) sawResp = 1'b1;
        end
        checkOutput("no_resp_after_abort", 64'(sawResp), 64'd0);
        checkOutput("csb_onehot_sdo_idle", 64'(mViol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
